// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential signed multiply/divide unit.
// Contents: FSM state encoding and operation select encoding.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/response bundle for mult_div_seq.
// master: drives start/op_div/a/b, observes busy/done/div_zero/hi/lo.
// slave : the arithmetic unit side.
interface mult_div_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op_div, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/md_sign_fix.sv
// Combinational sign helpers for mult_div_seq.
// op_a/op_b       : signed operands -> magnitudes and sign bits (operand load)
// fix_*/raw_hi/lo : unsigned iteration result -> signed result (FIX stage)
module md_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] abs_a_c,
  output logic [WIDTH-1:0] abs_b_c,
  output logic             sign_a_c,
  output logic             sign_b_c,
  input  logic             fix_div,
  input  logic             fix_neg_hi,
  input  logic             fix_neg_lo,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c
);
  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] prod;
  logic [PW-1:0] prod_neg;

  // Magnitudes; the most-negative value maps onto itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  always_comb begin
    sign_a_c = op_a[WIDTH-1];
    sign_b_c = op_b[WIDTH-1];
    abs_a_c  = sign_a_c ? (~op_a + WIDTH'(1)) : op_a;
    abs_b_c  = sign_b_c ? (~op_b + WIDTH'(1)) : op_b;
  end

  // Product negates as one double-width value; quotient/remainder separately.
  always_comb begin
    prod     = {raw_hi, raw_lo};
    prod_neg = ~prod + PW'(1);
    res_hi_c = raw_hi;
    res_lo_c = raw_lo;
    if (!fix_div) begin
      if (fix_neg_lo) {res_hi_c, res_lo_c} = prod_neg;
    end else begin
      if (fix_neg_lo) res_lo_c = ~raw_lo + WIDTH'(1);
      if (fix_neg_hi) res_hi_c = ~raw_hi + WIDTH'(1);
    end
  end
endmodule

// File: rtl/mult_div_seq.sv
// Sequential signed multiplier / divider, one bit per cycle.
// clk, reset (async active-low); bus: mult_div_seq_if slave
//   start/op_div/a/b in; busy/done/div_zero/hi/lo registered out.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_seq_if.slave  bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opd_q;
  logic             op_q, neg_hi_q, neg_lo_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_d, done_d, dz_d;

  logic [WIDTH-1:0] abs_a, abs_b, res_hi, res_lo;
  logic             sign_a, sign_b;

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op_a       (bus.a),
    .op_b       (bus.b),
    .abs_a_c    (abs_a),
    .abs_b_c    (abs_b),
    .sign_a_c   (sign_a),
    .sign_b_c   (sign_b),
    .fix_div    (op_q),
    .fix_neg_hi (neg_hi_q),
    .fix_neg_lo (neg_lo_q),
    .raw_hi     (acc_hi_q),
    .raw_lo     (acc_lo_q),
    .res_hi_c   (res_hi),
    .res_lo_c   (res_lo)
  );

  // One iteration step: multiply keeps {acc_hi,acc_lo} as the shifting
  // partial product; divide keeps remainder in acc_hi, quotient in acc_lo.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, div_diff;
  logic             div_ok;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ok   = (div_sh >= {1'b0, opd_q});
    // Remainder stays below the divisor, so the low WIDTH bits suffice.
    div_diff = div_sh[WIDTH-1:0] - opd_q;
    div_hi_n = div_ok ? div_diff : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo_q[WIDTH-2:0], div_ok};
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) begin
              if (bus.op_div == OP_DIV && bus.b == '0) state_d = DONE;
              else                                     state_d = CALC;
            end
      CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  // Output decode; div_zero only on the IDLE->DONE shortcut.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    dz_d   = (state_q == IDLE) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  // Operand load, iteration, and result write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opd_q    <= '0;
      op_q     <= OP_MUL;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (state_d == CALC) begin
                cnt_q    <= CNT_W'(WIDTH);
                acc_hi_q <= '0;
                acc_lo_q <= bus.op_div ? abs_a : abs_b;
                opd_q    <= bus.op_div ? abs_b : abs_a;
                op_q     <= bus.op_div;
                neg_lo_q <= sign_a ^ sign_b;
                // Remainder follows the dividend; product uses one sign.
                neg_hi_q <= bus.op_div ? sign_a : (sign_a ^ sign_b);
              end
        CALC: begin
                cnt_q    <= cnt_q - CNT_W'(1);
                acc_hi_q <= op_q ? div_hi_n : mul_hi_n;
                acc_lo_q <= op_q ? div_lo_n : mul_lo_n;
              end
        FIX:  begin
                hi_q <= res_hi;
                lo_q <= res_lo;
              end
        DONE: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_seq;
  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_div_seq_if #(.WIDTH(W)) bus ();
  mult_div_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] mdl_hi   = '0;
  logic [W-1:0] mdl_lo   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic exp_t model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    if (!op) begin
      p    = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi = mdl_hi;
      e.lo = mdl_lo;
      e.dz = 1'b1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    mdl_hi = e.hi;
    mdl_lo = e.lo;
    return e;
  endfunction

  // Monitor
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", 64'(bus.hi), 64'(mon_e.hi));
        check("lo", 64'(bus.lo), 64'(mon_e.lo));
        check("div_zero", 64'(bus.div_zero), 64'(mon_e.dz));
      end
    end
  end

  // Issue one operation; p1/p2 are cycles in which a stray start is pulsed.
  task automatic run_op(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int p1, input int p2, input string tag);
    int n;
    bit seen;
    int exp_lat;
    exp_lat = (op && b == '0) ? 1 : int'(W) + 2;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = op;
    bus.a      = a;
    bus.b      = b;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_div = 1'($urandom);
    bus.a      = W'($urandom);
    bus.b      = W'($urandom);
    n    = 1;
    seen = 1'b0;
    while (!seen && n <= 100) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
      end else begin
        check({tag, "_busy"}, 64'(bus.busy), 64'(1));
      end
      bus.start = (n == p1 || n == p2);
      if (!seen) begin
        @(negedge clk);
        bus.start = 1'b0;
        n++;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'(0), 64'(1));
      exp_q.delete();
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_idle_done"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rop;
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.a      = '0;
    bus.b      = '0;

    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_dz",   64'(bus.div_zero), 64'(0));
    check("rst_hi",   64'(bus.hi), 64'(0));
    check("rst_lo",   64'(bus.lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Most-negative squared, with stray starts mid-run and during DONE.
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 5, 34, "mul_minsq");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1, "div_7_m2");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, "div_m7_2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, "div_min_m1");
    run_op(1'b0, 32'hFFFF_FFFB, 32'd9, -1, -1, "mul_m5_9");
    run_op(1'b1, 32'd5, 32'd0, -1, -1, "div_by0");
    run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, -1, "mul_maxsq");
    run_op(1'b1, 32'd3, 32'd10, -1, -1, "div_small");

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom);
      ra  = W'($urandom);
      rb  = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = W'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb, -1, -1, "rand");
    end

    // Abort a divide with reset at cycle 10.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = 1'b1;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < 10; n++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_dz",   64'(bus.div_zero), 64'(0));
    check("abort_hi",   64'(bus.hi), 64'(0));
    check("abort_lo",   64'(bus.lo), 64'(0));
    mdl_hi = '0;
    mdl_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_op(1'b0, 32'd3, 32'd4, -1, -1, "mul_3_4");
    repeat (4) @(negedge clk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand width in bits (legal 8..64, even).
REQ-002 SHALL have parameter: CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: op_div  input  1  0 = signed multiply, 1 = signed divide.
REQ-007 SHALL have ports: a, b  input  WIDTH each  multiplicand/dividend (a), multiplier/divisor (b), two's complement.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-009 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port: div_zero  output  1  pulses with done when a divide had b = 0.
REQ-011 SHALL have ports: hi, lo  output  WIDTH each  result registers, held between operations.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: start=1 and not (op_div=1 and b=0) -> CALC; load |a|, |b|, result signs, counter = WIDTH.
REQ-014 IDLE: start=1, op_div=1, b=0 -> DONE directly; hi/lo unchanged; div_zero=1 in DONE.
REQ-015 CALC: one unsigned shift-add (mult) or restoring shift-subtract (div) step per cycle; counter decrements; counter reaching 0 -> FIX.
REQ-016 FIX: apply sign correction; DONE is entered on the next edge with hi/lo written on that edge.
REQ-017 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-018 Latency: start sampled at edge 0 -> done high during cycle WIDTH+2; divide-by-zero -> done high during cycle 1.
REQ-019 Multiply result: {hi,lo} = full 2*WIDTH-bit signed product.
REQ-020 Divide result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-021 Divide of most-negative value by -1 SHALL give lo = most-negative value, hi = 0, div_zero = 0.
REQ-022 start while busy=1, including during DONE, SHALL be ignored, with no queuing.
REQ-023 a, b, op_div SHALL be don't-care after the accepting edge; internal copies are used.
REQ-024 hi/lo SHALL change only on the edge entering DONE after a non-zero-divisor operation.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0.
REQ-026 reset asserted mid-operation SHALL abort with no done pulse; the first start after release is accepted normally.

Structure
REQ-027 Shared package mult_div_pkg SHALL hold state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3) and op encodings (OP_MUL=1'b0, OP_DIV=1'b1).
REQ-028 Sub-module md_sign_fix SHALL provide combinational abs/negate helpers for operand load and the FIX stage; the FSM and iteration datapath SHALL live in mult_div_seq.

Verification (WIDTH=32)
REQ-029 mult a=-2^31, b=-2^31 -> done at cycle 34, hi=0x40000000, lo=0x00000000.
REQ-030 div a=7, b=-2 -> lo=0xFFFFFFFD, hi=0x00000001; div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 div a=0x80000000, b=-1 -> lo=0x80000000, hi=0, div_zero=0.
REQ-032 div a=5, b=0 with hi/lo preloaded from a prior mult -> done and div_zero high at cycle 1, hi/lo unchanged.
REQ-033 start pulsed at cycles 5 and 34 of a running mult -> single done; both pulses ignored; busy continuous.
REQ-034 reset low at cycle 10 of a div -> outputs zero immediately, no done; new mult 3*4 after release -> lo=12, hi=0.
